// File: rtl/snd_mix10.sv
// Time-multiplexed channel mixer feeding the 10-bit sigma-delta DAC.
// One shared multiplier, serial accumulate, shift/saturate, excess-512 out.
module snd_mix10 #(
  parameter int NCH   = 4,
  parameter int W     = 12,
  parameter int GW    = 4,
  parameter int SHIFT = 6
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              SMP_STB,
  input  logic [NCH*W-1:0]  CH_IN,
  input  logic [NCH*GW-1:0] GAIN,
  input  logic              MUTE,
  output logic [9:0]        OUT,
  output logic              VALID,
  output logic              BUSY,
  output logic              CLIP,
  output logic              OVR
);

  localparam int AW = W + GW + $clog2(NCH);
  localparam int IW = $clog2(NCH);

  localparam logic signed [AW-1:0] P_MAX = AW'(511);
  localparam logic signed [AW-1:0] P_MIN = -AW'(512);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_SAT
  } state_t;

  state_t r_state;
  state_t w_nxt;

  logic [NCH*W-1:0]  r_ch;
  logic [NCH*GW-1:0] r_gain;
  logic              r_mute;
  logic [IW-1:0]     r_idx;
  logic signed [AW-1:0] r_acc;
  logic [9:0]        r_out;
  logic              r_valid;
  logic              r_clip;
  logic              r_ovr;

  logic [W-1:0]         w_ch;
  logic [GW-1:0]        w_g;
  logic signed [AW-1:0] w_chx;
  logic signed [AW-1:0] w_gx;
  logic signed [AW-1:0] w_prod;
  logic signed [AW-1:0] w_s;
  logic [9:0]           w_c;
  logic                 w_clip;
  logic                 w_last;

  assign w_ch   = r_ch[r_idx*W +: W];
  assign w_g    = r_gain[r_idx*GW +: GW];
  // Gain is zero-extended so it can never act as a negative factor.
  assign w_chx  = {{(AW-W){w_ch[W-1]}}, w_ch};
  assign w_gx   = {{(AW-GW){1'b0}}, w_g};
  assign w_prod = w_chx * w_gx;
  assign w_s    = r_acc >>> SHIFT;
  assign w_last = (r_idx == IW'(NCH-1));

  always_comb begin
    w_c    = w_s[9:0];
    w_clip = 1'b0;
    unique case (1'b1)
      (w_s > P_MAX): begin
        w_c    = 10'h1FF;
        w_clip = 1'b1;
      end
      (w_s < P_MIN): begin
        w_c    = 10'h200;
        w_clip = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (SMP_STB) w_nxt = S_ACC;
      S_ACC:   if (w_last)  w_nxt = S_SAT;
      S_SAT:   w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_ch    <= '0;
      r_gain  <= '0;
      r_mute  <= 1'b0;
      r_idx   <= '0;
      r_acc   <= '0;
      r_out   <= 10'h200;
      r_valid <= 1'b0;
      r_clip  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (SMP_STB && r_state != S_IDLE) r_ovr <= 1'b1;
      unique case (r_state)
        S_IDLE: begin
          if (SMP_STB) begin
            r_ch   <= CH_IN;
            r_gain <= GAIN;
            r_mute <= MUTE;
            r_acc  <= '0;
            r_idx  <= '0;
          end
        end
        S_ACC: begin
          r_acc <= r_acc + w_prod;
          r_idx <= r_idx + 1'b1;
        end
        S_SAT: begin
          r_out   <= r_mute ? 10'h200 : {~w_c[9], w_c[8:0]};
          r_clip  <= r_mute ? 1'b0 : w_clip;
          r_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign OUT   = r_out;
  assign VALID = r_valid;
  assign BUSY  = (r_state != S_IDLE);
  assign CLIP  = r_clip;
  assign OVR   = r_ovr;

endmodule

// File: tb/tb_snd_mix10.sv
// Scoreboard bench for snd_mix10: directed corner cases plus random mixes
// checked against an integer-arithmetic reference model.
module tb_snd_mix10;

  localparam int NCH   = 4;
  localparam int W     = 12;
  localparam int GW    = 4;
  localparam int SHIFT = 6;
  localparam int PER   = 10;

  logic              CLK = 1'b0;
  logic              Reset = 1'b1;
  logic              SMP_STB = 1'b0;
  logic [NCH*W-1:0]  CH_IN = '0;
  logic [NCH*GW-1:0] GAIN = '0;
  logic              MUTE = 1'b0;
  logic [9:0]        OUT;
  logic              VALID;
  logic              BUSY;
  logic              CLIP;
  logic              OVR;

  snd_mix10 #(.NCH(NCH), .W(W), .GW(GW), .SHIFT(SHIFT)) dut (
    .CLK(CLK), .Reset(Reset), .SMP_STB(SMP_STB),
    .CH_IN(CH_IN), .GAIN(GAIN), .MUTE(MUTE),
    .OUT(OUT), .VALID(VALID), .BUSY(BUSY),
    .CLIP(CLIP), .OVR(OVR)
  );

  always #(PER/2) CLK = ~CLK;

  typedef struct {
    int  out;
    bit  clip;
    time t0;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  int cur_ch[NCH];
  int cur_g[NCH];
  bit cur_m;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference: exact integer sum, floor division, clamp, offset by 512.
  function automatic exp_t ref_mix();
    exp_t e;
    int sum, div, s;
    sum = 0;
    for (int k = 0; k < NCH; k++) sum += cur_ch[k] * cur_g[k];
    div = 1 << SHIFT;
    s = sum / div;
    if (sum < 0 && (sum % div) != 0) s -= 1;
    e.clip = 1'b0;
    if (s > 511) begin s = 511; e.clip = 1'b1; end
    if (s < -512) begin s = -512; e.clip = 1'b1; end
    e.out = s + 512;
    if (cur_m) begin e.out = 'h200; e.clip = 1'b0; end
    e.t0 = 0;
    return e;
  endfunction

  task automatic apply();
    for (int k = 0; k < NCH; k++) begin
      logic [W-1:0]  cv;
      logic [GW-1:0] gv;
      cv = W'(cur_ch[k]);
      gv = GW'(cur_g[k]);
      CH_IN[k*W +: W]   = cv;
      GAIN[k*GW +: GW]  = gv;
    end
    MUTE = cur_m;
  endtask

  // Called just after a posedge; strobe sampled at the next edge (E0).
  task automatic strobe(input bit push, output time t0);
    exp_t e;
    apply();
    e = ref_mix();
    SMP_STB = 1'b1;
    @(posedge CLK);
    t0 = $time;
    e.t0 = t0;
    if (push) q.push_back(e);
    #1;
    SMP_STB = 1'b0;
    CH_IN = {$urandom, $urandom};
    GAIN  = NCH*GW'($urandom);
    MUTE  = ~MUTE;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic set_case2();
    for (int k = 0; k < NCH; k++) begin cur_ch[k] = 0; cur_g[k] = 0; end
    cur_ch[0] = 1024;
    cur_g[0]  = 4;
    cur_m     = 1'b0;
  endtask

  task automatic set_all(input int v, input int g, input bit m);
    for (int k = 0; k < NCH; k++) begin cur_ch[k] = v; cur_g[k] = g; end
    cur_m = m;
  endtask

  // Monitor: every VALID pops one expected result and checks value and latency.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (VALID) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          e = q.pop_front();
          chk("out", int'(OUT), e.out);
          chk("clip", int'(CLIP), int'(e.clip));
          chk("latency", int'(($time - e.t0) / PER), NCH + 1);
          chk("busy_at_valid", int'(BUSY), 0);
        end
      end
    end
  end

  initial begin
    time t0;
    int  nb;
    repeat (3) @(posedge CLK);
    #1;
    Reset = 1'b0;
    @(negedge CLK);
    chk("rst_out", int'(OUT), 'h200);
    chk("rst_valid", int'(VALID), 0);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_clip", int'(CLIP), 0);
    chk("rst_ovr", int'(OVR), 0);
    idle(4);
    @(negedge CLK);
    chk("idle_out", int'(OUT), 'h200);
    chk("idle_busy", int'(BUSY), 0);
    @(posedge CLK); #1;

    set_case2();
    strobe(1'b1, t0);
    nb = 0;
    for (int i = 0; i < NCH + 3; i++) begin
      @(negedge CLK);
      if (BUSY) nb++;
    end
    chk("busy_cycles", nb, NCH + 1);
    chk("case2_hold", int'(OUT), 'h240);
    @(posedge CLK); #1;

    set_all(2047, 15, 1'b0);  strobe(1'b1, t0); idle(6);
    set_all(-2048, 15, 1'b0); strobe(1'b1, t0); idle(6);
    set_all(0, 0, 1'b0);
    cur_ch[0] = -1; cur_g[0] = 1;
    strobe(1'b1, t0); idle(6);

    set_case2();
    strobe(1'b1, t0);
    idle(1);
    set_all(2047, 15, 1'b0);
    strobe(1'b0, t0);
    idle(8);
    chk("ovr_set", int'(OVR), 1);
    set_all(-300, 7, 1'b0); strobe(1'b1, t0); idle(6);
    chk("ovr_sticky", int'(OVR), 1);

    set_case2();
    strobe(1'b0, t0);
    idle(1);
    Reset = 1'b1;
    @(posedge CLK); #1;
    Reset = 1'b0;
    @(negedge CLK);
    chk("mid_rst_out", int'(OUT), 'h200);
    chk("mid_rst_busy", int'(BUSY), 0);
    chk("mid_rst_ovr", int'(OVR), 0);
    idle(8);
    set_case2();
    strobe(1'b1, t0); idle(6);

    set_all(2047, 15, 1'b1);
    strobe(1'b1, t0); idle(6);

    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < NCH; k++) begin
        if ($urandom_range(0, 3) == 0)
          cur_ch[k] = $urandom_range(0, 1) ? 2047 : -2048;
        else
          cur_ch[k] = int'($urandom_range(0, 4095)) - 2048;
        cur_g[k] = $urandom_range(0, 15);
      end
      cur_m = ($urandom_range(0, 7) == 0);
      strobe(1'b1, t0);
      idle(5 + $urandom_range(0, 3));
    end

    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge CLK);
    @(negedge CLK);
    chk("drain", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
